// File: rtl/periph_pkg.sv
// Shared peripheral map: base addresses, switch-input register offsets and bus width.
package periph_pkg;

    localparam int BUS_W = 32;

    localparam logic [BUS_W-1:0] GPIO_BASE = 32'h8000_0000;
    localparam logic [BUS_W-1:0] SWIN_BASE = 32'h8000_0010;

    localparam int SWIN_NREGS = 3;

    typedef enum logic [1:0] {
        SWIN_STATE = 2'd0,
        SWIN_EDGE  = 2'd1,
        SWIN_MASK  = 2'd2
    } swin_reg_e;

endpackage

// File: rtl/sw_debounce_in_bit.sv
// One switch channel: two-flop synchroniser, stability counter, accepted level and
// a single-cycle accept strobe that fires on the clock the accepted level changes.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic ACLK,
    input  logic RESET,
    input  logic sw,
    output logic stable,
    output logic accept
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    // Combinational so the top can set the flag on the same edge the level is taken.
    assign accept = (sync != stable) && (cnt == CNT_MAX);

    always_ff @(posedge ACLK or posedge RESET) begin
        if (RESET) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            meta <= sw;
            sync <= meta;
            if (sync == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_debounce_in.sv
// Switch-input peripheral: debounced STATE, sticky W1C EDGE flags, registered bus reads.
// Define SWIN_IRQ_EN to build the MASK register and the IRQ output.
module sw_debounce_in
    import periph_pkg::*;
#(
    parameter logic [31:0] BASEADDRESS     = SWIN_BASE,
    parameter int          NBITS           = 18,
    parameter int          DEBOUNCE_CYCLES = 50000
) (
    input  logic             ACLK,
    input  logic             RESET,
    input  logic [NBITS-1:0] SW,
    input  logic [31:0]      ADDR,
    input  logic [31:0]      DATA_I,
    input  logic             WRSTB,
    input  logic             RDSTB,
`ifdef SWIN_IRQ_EN
    output logic             IRQ,
`endif
    output logic [31:0]      DATA_O
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [NBITS-1:0] state;
    logic [NBITS-1:0] accept;
    logic [NBITS-1:0] edge_q;
    logic [NBITS-1:0] mask_q;
    logic [31:0]      idx;
    logic             sel;
    logic             wr_edge;
    logic             wr_mask;
    logic             rd;
    logic [31:0]      clr;

    for (genvar i = 0; i < NBITS; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .ACLK  (ACLK),
            .RESET (RESET),
            .sw    (SW[i]),
            .stable(state[i]),
            .accept(accept[i])
        );
    end

    // Unsigned offset: addresses below the base wrap to large values and deselect.
    assign idx     = ADDR - BASEADDRESS;
    assign sel     = (idx < SWIN_NREGS);
    assign wr_edge = WRSTB && sel && (idx[1:0] == SWIN_EDGE);
    assign wr_mask = WRSTB && sel && (idx[1:0] == SWIN_MASK);
    assign rd      = RDSTB && !WRSTB && sel;
    assign clr     = wr_edge ? DATA_I : '0;

    // Set is OR-ed in after the clear so a same-cycle accept keeps the flag.
    always_ff @(posedge ACLK or posedge RESET) begin
        if (RESET) edge_q <= '0;
        else       edge_q <= (edge_q & ~clr[NBITS-1:0]) | accept;
    end

`ifdef SWIN_IRQ_EN
    always_ff @(posedge ACLK or posedge RESET) begin
        if (RESET) begin
            mask_q <= '0;
            IRQ    <= 1'b0;
        end else begin
            if (wr_mask) mask_q <= DATA_I[NBITS-1:0];
            IRQ <= |(edge_q & mask_q);
        end
    end
`else
    assign mask_q = '0;
    logic unused_wr_mask;
    assign unused_wr_mask = wr_mask;
`endif

    always_ff @(posedge ACLK or posedge RESET) begin
        if (RESET) begin
            DATA_O <= '0;
        end else begin
            DATA_O <= '0;
            if (rd) begin
                case (idx[1:0])
                    SWIN_STATE: DATA_O <= 32'(state);
                    SWIN_EDGE:  DATA_O <= 32'(edge_q);
                    SWIN_MASK:  DATA_O <= 32'(mask_q);
                    default:    DATA_O <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sw_debounce_in.sv
// Bench for sw_debounce_in (DEBOUNCE_CYCLES=4): directed corners, a bus-op table and a
// randomized run against a run-length reference model. Honours SWIN_IRQ_EN.
module tb_sw_debounce_in;

    localparam int          NB   = 18;
    localparam int          DC   = 4;
    localparam logic [31:0] BASE = 32'h8000_0010;
`ifdef SWIN_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic          ACLK = 1'b0;
    logic          RESET = 1'b1;
    logic [NB-1:0] SW = '0;
    logic [31:0]   ADDR = '0;
    logic [31:0]   DATA_I = '0;
    logic          WRSTB = 1'b0;
    logic          RDSTB = 1'b0;
    logic [31:0]   DATA_O;
    logic          IRQ;

    int checks = 0;
    int errors = 0;

    sw_debounce_in #(.BASEADDRESS(BASE), .NBITS(NB), .DEBOUNCE_CYCLES(DC)) dut (
        .ACLK  (ACLK),
        .RESET (RESET),
        .SW    (SW),
        .ADDR  (ADDR),
        .DATA_I(DATA_I),
        .WRSTB (WRSTB),
        .RDSTB (RDSTB),
`ifdef SWIN_IRQ_EN
        .IRQ   (IRQ),
`endif
        .DATA_O(DATA_O)
    );
`ifndef SWIN_IRQ_EN
    assign IRQ = 1'b0;
`endif

    always #5 ACLK = ~ACLK;

    // Reference: history of SW samples; a bit is accepted once the level seen two
    // samples back has differed from the accepted level for DC consecutive clocks.
    logic [NB-1:0] hist1, hist2, m_state, m_edge, m_mask;
    int            run [NB];
    logic [31:0]   m_dout;
    logic          m_irq;

    function automatic void model_reset();
        hist1 = '0; hist2 = '0; m_state = '0; m_edge = '0; m_mask = '0;
        m_dout = '0; m_irq = 1'b0;
        for (int i = 0; i < NB; i++) run[i] = 0;
    endfunction

    function automatic void model_step();
        logic [31:0] off;
        logic [31:0] nd;
        logic        ni;
        off = ADDR - BASE;
        nd  = '0;
        if (RDSTB && !WRSTB && off < 3) begin
            if (off == 0)      nd = 32'(m_state);
            else if (off == 1) nd = 32'(m_edge);
            else               nd = IRQ_EN ? 32'(m_mask) : 32'd0;
        end
        ni = IRQ_EN && ((m_edge & m_mask) != 0);
        if (WRSTB && off == 1) m_edge = m_edge & ~DATA_I[NB-1:0];
        if (WRSTB && off == 2 && IRQ_EN) m_mask = DATA_I[NB-1:0];
        for (int i = 0; i < NB; i++) begin
            if (hist2[i] == m_state[i]) run[i] = 0;
            else begin
                run[i]++;
                if (run[i] == DC) begin
                    m_state[i] = hist2[i];
                    m_edge[i]  = 1'b1;
                    run[i]     = 0;
                end
            end
        end
        hist2  = hist1;
        hist1  = SW;
        m_dout = nd;
        m_irq  = ni;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge ACLK);
        model_step();
        #1;
        chk("data_o_model", DATA_O, m_dout);
        if (IRQ_EN) chk("irq_model", 32'(IRQ), 32'(m_irq));
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        ADDR = a; DATA_I = d; WRSTB = w; RDSTB = r;
        tick();
        WRSTB = 1'b0; RDSTB = 1'b0;
    endtask

    task automatic rd_exp(input string name, input logic [31:0] off, input logic [31:0] exp);
        bus(BASE + off, 32'd0, 1'b0, 1'b1);
        chk(name, DATA_O, exp);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #1;
        model_reset();
        chk("rst_data_o", DATA_O, 32'd0);
        chk("rst_irq", 32'(IRQ), 32'd0);
        repeat (2) @(posedge ACLK);
        #1;
        RESET = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        logic        rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [$];

    initial begin
        // 1: reset in the middle of a count
        do_reset();
        repeat (2) tick();
        SW = '1;
        repeat (3) tick();
        do_reset();
        rd_exp("t1_state_after_rst", 0, 32'h0);
        rd_exp("t1_edge_after_rst", 1, 32'h0);
        repeat (3) tick();
        rd_exp("t1_state_pre_accept", 0, 32'h0);
        rd_exp("t1_state_accepted", 0, 32'h3FFFF);
        rd_exp("t1_edge_all", 1, 32'h3FFFF);

        // 2: bounce rejected, then clean step with exact latency
        SW = '0;
        do_reset();
        SW[0] = 1'b1;
        repeat (3) tick();
        SW[0] = 1'b0;
        repeat (8) tick();
        rd_exp("t2_bounce_state", 0, 32'h0);
        rd_exp("t2_bounce_edge", 1, 32'h0);
        SW[0] = 1'b1;
        repeat (5) tick();
        rd_exp("t2_state_5clk", 0, 32'h0);
        rd_exp("t2_state_6clk", 0, 32'h1);
        rd_exp("t2_edge", 1, 32'h1);

        // 3: W1C, and set beating clear on the same clock
        SW = 18'h5;
        repeat (8) tick();
        rd_exp("t3_edge5", 1, 32'h5);
        bus(BASE + 1, 32'h1, 1'b1, 1'b0);
        rd_exp("t3_edge_w1c", 1, 32'h4);
        SW[2] = 1'b0;
        repeat (5) tick();
        bus(BASE + 1, 32'h4, 1'b1, 1'b0);
        rd_exp("t3_set_wins", 1, 32'h4);
        rd_exp("t3_state", 0, 32'h1);

        // 4 and 6: table of single bus operations, DATA_O checked after each
        vt.push_back('{BASE,       32'h0,        1'b0, 1'b1, 32'h1});
        vt.push_back('{BASE,       32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0});
        vt.push_back('{BASE,       32'h0,        1'b0, 1'b1, 32'h1});
        vt.push_back('{BASE + 3,   32'h0,        1'b0, 1'b1, 32'h0});
        vt.push_back('{BASE - 1,   32'h0,        1'b0, 1'b1, 32'h0});
        vt.push_back('{BASE,       32'h0,        1'b1, 1'b1, 32'h0});
        vt.push_back('{BASE + 1,   32'h0,        1'b0, 1'b0, 32'h0});
        vt.push_back('{BASE + 1,   32'h0,        1'b0, 1'b1, 32'h4});
        vt.push_back('{BASE + 2,   32'h3,        1'b1, 1'b0, 32'h0});
        vt.push_back('{BASE + 2,   32'h0,        1'b0, 1'b1, IRQ_EN ? 32'h3 : 32'h0});
        vt.push_back('{BASE + 2,   32'h0,        1'b1, 1'b1, 32'h0});
        vt.push_back('{BASE + 2,   32'h0,        1'b0, 1'b1, 32'h0});
        foreach (vt[k]) begin
            bus(vt[k].addr, vt[k].data, vt[k].wr, vt[k].rd);
            chk($sformatf("t4_vec%0d", k), DATA_O, vt[k].exp);
        end

        // 5: IRQ follows masked flags one clock late
        if (IRQ_EN) begin
            bus(BASE + 1, 32'h3FFFF, 1'b1, 1'b0);
            bus(BASE + 2, 32'h2, 1'b1, 1'b0);
            SW[0] = 1'b0;
            repeat (8) tick();
            chk("t5_irq_unmasked", 32'(IRQ), 32'd0);
            SW[1] = 1'b1;
            repeat (6) tick();
            chk("t5_irq_same_clk", 32'(IRQ), 32'd0);
            tick();
            chk("t5_irq_set", 32'(IRQ), 32'd1);
            bus(BASE + 1, 32'h2, 1'b1, 1'b0);
            chk("t5_irq_hold", 32'(IRQ), 32'd1);
            tick();
            chk("t5_irq_clr", 32'(IRQ), 32'd0);
        end

        // Randomized traffic with bouncing switches
        for (int c = 0; c < 3000; c++) begin
            int r;
            if ($urandom_range(0, 5) == 0) SW[$urandom_range(0, NB - 1)] ^= 1'b1;
            r = int'($urandom_range(0, 9));
            ADDR   = BASE - 1 + $urandom_range(0, 4);
            DATA_I = $urandom;
            WRSTB  = (r == 4 || r == 5 || r == 6);
            RDSTB  = (r <= 3 || r == 6);
            tick();
            WRSTB = 1'b0; RDSTB = 1'b0;
        end
        repeat (10) tick();
        rd_exp("rand_state_final", 0, 32'(m_state));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
